// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter fed by CPU stores, with a small TX FIFO and status register.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_mmio #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  TX_ADDR    = 8'hFE,
  parameter logic [7:0]  STAT_ADDR  = 8'hFD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       txd,
  output logic       busy,
  output logic       fifo_full
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W        = PTR_W + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // Store decode with edge detection so a long CPU strobe acts once
  logic wr_tx, wr_stat, wr_tx_q, wr_stat_q, push, clr_ovf;

  assign wr_tx   = we && (addr == TX_ADDR);
  assign wr_stat = we && (addr == STAT_ADDR);
  assign push    = wr_tx && !wr_tx_q;
  assign clr_ovf = wr_stat && !wr_stat_q && wdata[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_tx_q   <= 1'b0;
      wr_stat_q <= 1'b0;
    end else begin
      wr_tx_q   <= wr_tx;
      wr_stat_q <= wr_stat;
    end
  end

  // TX FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_n;
  logic             fifo_empty, pop, push_ok, overflow;
  logic [7:0]       head;

  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign push_ok    = push && (!fifo_full || pop);
  assign count_n    = count + CNT_W'(push_ok) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_n;
      fifo_full <= (count_n == CNT_W'(FIFO_DEPTH));
      if (push && !push_ok) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
    end
  end

  assign rdata = (addr == STAT_ADDR) ? {overflow, 4'b0000, fifo_full, ~fifo_empty, busy} : 8'h00;

  // Serializer
  state_t            state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [2:0]        bit_cnt, bit_n;
  logic [7:0]        data_q, data_n;
  logic              txd_n, busy_n, baud_done;

  assign baud_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      data_q   <= data_n;
      txd      <= txd_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    data_n  = data_q;
    txd_n   = txd;
    busy_n  = busy;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_n  = head;
          state_n = START;
          txd_n   = 1'b0;
          busy_n  = 1'b1;
          baud_n  = '0;
        end
      end
      START: begin
        baud_n = baud_done ? '0 : baud_cnt + BAUD_W'(1);
        if (baud_done) begin
          bit_n   = '0;
          state_n = DATA;
          txd_n   = data_q[0];
        end
      end
      DATA: begin
        baud_n = baud_done ? '0 : baud_cnt + BAUD_W'(1);
        if (baud_done) begin
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            txd_n   = ^data_q;
`else
            state_n = STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            bit_n = bit_cnt + 3'd1;
            txd_n = data_q[bit_n];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        baud_n = baud_done ? '0 : baud_cnt + BAUD_W'(1);
        if (baud_done) begin
          state_n = STOP;
          txd_n   = 1'b1;
        end
      end
`endif
      STOP: begin
        baud_n = baud_done ? '0 : baud_cnt + BAUD_W'(1);
        if (baud_done) begin
          // Chain straight into the next start bit when more data is waiting
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_n  = head;
            state_n = START;
            txd_n   = 1'b0;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
